// File: rtl/cfg_pkg.sv
// Shared helpers and state encoding for the configuration chain loader.
package cfg_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (clog2(max_val + 1) < 1) ? 1 : clog2(max_val + 1);
  endfunction

  function automatic int nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_e;

endpackage

// File: rtl/cfg_word_skid.sv
// One-entry word buffer with valid/ready on both sides and a synchronous flush.
module cfg_word_skid #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_in_vld,
  output logic         o_in_rdy,
  input  logic [W-1:0] i_in_dat,
  output logic         o_out_vld,
  input  logic         i_out_rdy,
  output logic [W-1:0] o_out_dat
);

  logic         r_full;
  logic [W-1:0] r_dat;

  assign o_in_rdy  = !r_full;
  assign o_out_vld = r_full;
  assign o_out_dat = r_dat;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_full <= 1'b0;
      r_dat  <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_in_vld && !r_full) begin
      r_full <= 1'b1;
      r_dat  <= i_in_dat;
    end else if (r_full && i_out_rdy) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises framed config words LSB-first into the switch-block chain and strobes set_in
// once all CHAIN_LEN bits are in; malformed or aborted frames are never committed.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [WORD_W-1:0] i_cfg_data,
  input  logic              i_cfg_last,
  input  logic              i_abort,
  output logic              o_cen,
  output logic              o_shift_in,
  output logic              o_set_in,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int NW  = nwords(CHAIN_LEN, WORD_W);
  localparam int BW  = cnt_w(CHAIN_LEN - 1);
  localparam int WBW = cnt_w(WORD_W - 1);
  localparam int NWW = cnt_w(NW);

  state_e            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_sh;
  logic              r_sh_vld;
  logic [BW-1:0]     r_bit_cnt;
  logic [WBW-1:0]    r_wbit;
  logic [NWW-1:0]    r_word_cnt;
  logic              r_err;

  logic              w_buf_vld, w_buf_in_rdy, w_buf_push, w_buf_pop, w_flush;
  logic [WORD_W-1:0] w_buf_dat;
  logic              w_acc, w_len_err, w_final_bit, w_word_end, w_sh_free, w_frame_open;

  assign o_cen       = (r_state == SHIFT) && r_sh_vld;
  assign o_shift_in  = o_cen && r_sh[0];
  assign o_err       = r_err;
  assign w_final_bit = o_cen && (r_bit_cnt == BW'(CHAIN_LEN - 1));
  assign w_word_end  = o_cen && (r_wbit == WBW'(WORD_W - 1)) && !w_final_bit;
  assign w_sh_free   = !r_sh_vld || w_word_end;

  // Once the final word of a frame is taken, hold off the next frame until IDLE.
  assign w_frame_open = (r_state == IDLE) || ((r_state == SHIFT) && (r_word_cnt != NWW'(NW)));
  assign o_cfg_ready  = w_buf_in_rdy && w_frame_open && !i_abort;
  assign w_acc        = i_cfg_valid && o_cfg_ready;
  assign w_len_err    = w_acc && (i_cfg_last ? (r_word_cnt < NWW'(NW - 1))
                                             : (r_word_cnt == NWW'(NW - 1)));

  assign w_buf_push = w_acc && !w_len_err && !w_sh_free;
  assign w_buf_pop  = (r_state == SHIFT) && w_sh_free && !w_final_bit && !i_abort;
  assign w_flush    = i_abort || w_len_err;

  cfg_word_skid #(.W(WORD_W)) u_skid (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_flush   (w_flush),
    .i_in_vld  (w_buf_push),
    .o_in_rdy  (w_buf_in_rdy),
    .i_in_dat  (i_cfg_data),
    .o_out_vld (w_buf_vld),
    .i_out_rdy (w_buf_pop),
    .o_out_dat (w_buf_dat)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_set_in    = 1'b0;
    o_done      = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      IDLE:   if (w_acc && !w_len_err) w_state_nxt = SHIFT;
      SHIFT: begin
        o_busy = 1'b1;
        if (w_len_err)        w_state_nxt = IDLE;
        else if (w_final_bit) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        o_busy      = 1'b1;
        o_set_in    = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sh       <= '0;
      r_sh_vld   <= 1'b0;
      r_bit_cnt  <= '0;
      r_wbit     <= '0;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_state_nxt == IDLE) begin
      r_sh_vld   <= 1'b0;
      r_bit_cnt  <= '0;
      r_wbit     <= '0;
      r_word_cnt <= '0;
      if (w_len_err) r_err <= 1'b1;
    end else begin
      if (w_acc)                      r_word_cnt <= r_word_cnt + NWW'(1);
      if (w_acc && r_state == IDLE)   r_err      <= 1'b0;
      if (o_cen) begin
        r_sh      <= r_sh >> 1;
        r_bit_cnt <= r_bit_cnt + BW'(1);
        r_wbit    <= r_wbit + WBW'(1);
      end
      // A buffered word takes priority; a fresh word bypasses the buffer when it is empty.
      if (w_final_bit) begin
        r_sh_vld <= 1'b0;
      end else if (w_sh_free) begin
        if (w_buf_vld) begin
          r_sh     <= w_buf_dat;
          r_sh_vld <= 1'b1;
          r_wbit   <= '0;
        end else if (w_acc) begin
          r_sh     <= i_cfg_data;
          r_sh_vld <= 1'b1;
          r_wbit   <= '0;
        end else begin
          r_sh_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader with a bit-stream model checked every cycle.
module tb_cfg_chain_loader;

  localparam int CL = 40;
  localparam int NW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        abort = 1'b0;
  logic        cen, shift_in, set_in, busy, done, err;

  always #5 clk = ~clk;

  cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_data  (cfg_data),
    .i_cfg_last  (cfg_last),
    .i_abort     (abort),
    .o_cen       (cen),
    .o_shift_in  (shift_in),
    .o_set_in    (set_in),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  int checks = 0;
  int errors = 0;

  // Model: the frame's expected bit stream, position in it, and frame-level expectations.
  logic [CL-1:0] m_stream = '0;
  logic [63:0]   cap = '0;
  int            m_idx = 0, m_run = 0, m_maxrun = 0, m_sets = 0, m_widx = 0;
  bit            m_commit = 0, m_set_seen = 0, m_prev_set = 0, m_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic start_frame(input logic [47:0] ws, input bit commit);
    m_stream   = ws[CL-1:0];
    m_idx      = 0;
    m_commit   = commit;
    m_set_seen = 0;
    m_sets     = 0;
    m_maxrun   = 0;
    cap        = '0;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    #1;
    while (!cfg_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_wait", 64'(cfg_ready), 64'(1));
    if (!cfg_ready) begin
      cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    if (m_widx == 0) m_err = 0;
    if ((l && m_widx < NW - 1) || (!l && m_widx == NW - 1)) begin
      m_err  = 1;
      m_widx = 0;
    end else if (l) m_widx = 0;
    else m_widx++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
    @(negedge clk);
  endtask

  task automatic wait_shift_stop();
    int n;
    n = 0;
    @(negedge clk);
    while (cen && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("gap_cen_low", 64'(cen), 64'(0));
      @(negedge clk);
    end
  endtask

  task automatic wait_bit(input int b);
    int n;
    n = 0;
    while (m_idx < b && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("reach_bit", 64'(m_idx), 64'(b));
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_cen"},   64'(cen),       64'(0));
    chk({nm, "_sin"},   64'(shift_in),  64'(0));
    chk({nm, "_set"},   64'(set_in),    64'(0));
    chk({nm, "_busy"},  64'(busy),      64'(0));
    chk({nm, "_done"},  64'(done),      64'(0));
    chk({nm, "_ready"}, 64'(cfg_ready), 64'(1));
  endtask

  // Per-cycle compare against the model.
  initial begin
    bit exp_set;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_set = m_commit && (m_idx == CL) && !m_set_seen;
        chk("set_in", 64'(set_in), 64'(exp_set));
        chk("done", 64'(done), 64'(m_prev_set));
        chk("err", 64'(err), 64'(m_err));
        chk("cen_set_excl", 64'(cen & set_in), 64'(0));
        if (!cen) chk("shift_idle", 64'(shift_in), 64'(0));
        if (cen || set_in) chk("busy_active", 64'(busy), 64'(1));
        if (done) chk("busy_done", 64'(busy), 64'(0));
        if (cen) begin
          if (m_idx < CL) chk("shift_bit", 64'(shift_in), 64'(m_stream[m_idx]));
          else chk("bit_overrun", 64'(m_idx), 64'(CL - 1));
          if (m_idx < 64) cap[m_idx] = shift_in;
          m_idx++;
          m_run++;
          if (m_run > m_maxrun) m_maxrun = m_run;
        end else m_run = 0;
        if (set_in) m_sets++;
        if (exp_set) m_set_seen = 1;
        m_prev_set = exp_set;
      end else begin
        m_prev_set = 0;
        m_run      = 0;
      end
    end
  end

  initial begin
    // Reset values.
    #12;
    check_idle("rst");
    chk("rst_err", 64'(err), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back frame.
    start_frame({16'h00C3, 16'h0F0F, 16'hA5A5}, 1);
    send(16'hA5A5, 0);
    chk("latency_cen", 64'(cen), 64'(1));
    chk("latency_bit0", 64'(shift_in), 64'(1));
    send(16'h0F0F, 0);
    send(16'h00C3, 1);
    wait_done();
    chk("b2b_run", 64'(m_maxrun), 64'(40));
    chk("b2b_bits", 64'(m_idx), 64'(40));
    chk("b2b_sets", 64'(m_sets), 64'(1));
    chk("b2b_stream", cap, 64'h00_C3_0F0F_A5A5);
    check_idle("b2b_end");

    // Gapped frame.
    start_frame({16'h0055, 16'hBEEF, 16'h1234}, 1);
    send(16'h1234, 0);
    wait_shift_stop();
    send(16'hBEEF, 0);
    wait_shift_stop();
    send(16'h0055, 1);
    wait_done();
    chk("gap_run", 64'(m_maxrun), 64'(16));
    chk("gap_bits", 64'(m_idx), 64'(40));
    chk("gap_sets", 64'(m_sets), 64'(1));
    chk("gap_stream", cap, 64'h00_55_BEEF_1234);

    // cfg_last on second word.
    start_frame({16'h0000, 16'h2222, 16'h1111}, 0);
    send(16'h1111, 0);
    wait_shift_stop();
    send(16'h2222, 1);
    chk("early_err", 64'(err), 64'(1));
    repeat (40) @(negedge clk);
    chk("early_sets", 64'(m_sets), 64'(0));
    chk("early_bits", 64'(m_idx), 64'(16));
    check_idle("early_end");

    // Recovery frame clears err and commits.
    start_frame({16'h0012, 16'hBEEF, 16'hDEAD}, 1);
    send(16'hDEAD, 0);
    chk("recover_err_clr", 64'(err), 64'(0));
    send(16'hBEEF, 0);
    send(16'h0012, 1);
    wait_done();
    chk("recover_sets", 64'(m_sets), 64'(1));
    chk("recover_stream", cap, 64'h00_12_BEEF_DEAD);

    // Abort at bit 20 with a word presented.
    start_frame({16'h7777, 16'h3C3C, 16'h9999}, 0);
    send(16'h9999, 0);
    send(16'h3C3C, 0);
    wait_bit(20);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = 16'h7777;
    cfg_last  = 1'b1;
    abort     = 1'b1;
    #1;
    chk("abort_ready", 64'(cfg_ready), 64'(0));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    m_widx    = 0;
    @(negedge clk);
    chk("abort_cen", 64'(cen), 64'(0));
    repeat (30) @(negedge clk);
    chk("abort_sets", 64'(m_sets), 64'(0));
    chk("abort_bits", 64'(m_idx), 64'(21));
    chk("abort_err", 64'(err), 64'(0));
    check_idle("abort_end");

    // Third word without cfg_last.
    start_frame({16'h0003, 16'h0002, 16'h0001}, 0);
    send(16'h0001, 0);
    send(16'h0002, 0);
    send(16'h0003, 0);
    chk("nolast_err", 64'(err), 64'(1));
    repeat (40) @(negedge clk);
    chk("nolast_sets", 64'(m_sets), 64'(0));
    check_idle("nolast_end");

    // Asynchronous reset at bit 30.
    start_frame({16'h00FF, 16'hAAAA, 16'h5555}, 0);
    send(16'h5555, 0);
    send(16'hAAAA, 0);
    send(16'h00FF, 1);
    wait_bit(30);
    #3;
    rst = 1'b0;
    m_err = 0;
    m_widx = 0;
    #1;
    check_idle("arst");
    chk("arst_err", 64'(err), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    start_frame({16'h0081, 16'h6006, 16'hF00D}, 1);
    send(16'hF00D, 0);
    send(16'h6006, 0);
    send(16'h0081, 1);
    wait_done();
    chk("post_rst_sets", 64'(m_sets), 64'(1));
    chk("post_rst_stream", cap, 64'h00_81_6006_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
